// File: rtl/fetch_pkg.sv
// Shared constants and ROM content generator for the fetch stage.
// Optional misalignment checking is enabled with FETCH_MISALIGN_CHK_EN.
package fetch_pkg;

  localparam int          INSTR_BYTES   = 4;
  localparam int          DEF_ADDR_W    = 32;
  localparam int          DEF_DATA_W    = 32;
  localparam int          DEF_BUF_DEPTH = 2;
  localparam int          DEF_MEM_WORDS = 64;
  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;

  // Instruction image: opcode byte, index, inverted index, trailer byte.
  function automatic logic [31:0] imem_word(input logic [7:0] idx);
    return {8'h13, idx, ~idx, 8'h93};
  endfunction

endpackage

// File: rtl/fetch_imem.sv
// Synchronous-read instruction ROM, one cycle of read latency.
// Contents come from the fetch_pkg::imem_word image generator.
module fetch_imem
  import fetch_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MEM_WORDS = DEF_MEM_WORDS,
  localparam int IDX_W    = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] rd_data_r;

  // Registered ROM read, only updated on an issued fetch
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      rd_data_r <= '0;
    end else if (rd_en) begin
      rd_data_r <= DATA_W'(imem_word(8'(rd_idx)));
    end else begin
      rd_data_r <= rd_data_r;
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, ROM read, and an output FIFO with redirect flush.
// Define FETCH_MISALIGN_CHK_EN to reject misaligned redirects via misalign_err.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int               ADDR_W    = DEF_ADDR_W,
  parameter int               DATA_W    = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
  parameter int               BUF_DEPTH = DEF_BUF_DEPTH,
  parameter int               MEM_WORDS = DEF_MEM_WORDS
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic              misalign_err
`endif
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic [ADDR_W-1:0] pc_r;
  logic              rd_valid_r;
  logic [ADDR_W-1:0] rd_pc_r;
  logic [DATA_W-1:0] rd_data_s;
  logic [DATA_W-1:0] buf_instr_r [BUF_DEPTH];
  logic [ADDR_W-1:0] buf_pc_r    [BUF_DEPTH];
  logic [PTR_W-1:0]  wptr_r;
  logic [PTR_W-1:0]  rptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  level_s;
  logic              pop_s;
  logic              redir_s;
  logic              issue_s;
  logic [ADDR_W-1:0] target_s;
`ifdef FETCH_MISALIGN_CHK_EN
  logic              misalign_s;
  logic              misalign_err_r;
`endif

  assign pop_s   = (count_r != CNT_W'(0)) && out_ready;
  assign level_s = count_r + CNT_W'(rd_valid_r);

  // Redirect acceptance and fetch-issue decision
  always_comb begin
    redir_s  = 1'b0;
    issue_s  = 1'b0;
    target_s = redirect_pc & ~ADDR_W'(2'b11);
`ifdef FETCH_MISALIGN_CHK_EN
    misalign_s = 1'b0;
    if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      misalign_s = 1'b1;
    end else begin
      redir_s = redirect_valid;
    end
`else
    redir_s = redirect_valid;
`endif
    // A pop frees a slot this same edge, so a full pipeline may still issue
    if (redir_s) begin
      issue_s = 1'b0;
    end else if (level_s < CNT_W'(BUF_DEPTH)) begin
      issue_s = 1'b1;
    end else if ((level_s == CNT_W'(BUF_DEPTH)) && pop_s) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // PC and in-flight read tracking
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      pc_r       <= RESET_PC;
      rd_valid_r <= 1'b0;
      rd_pc_r    <= '0;
    end else if (redir_s) begin
      pc_r       <= target_s;
      rd_valid_r <= 1'b0;
      rd_pc_r    <= rd_pc_r;
    end else if (issue_s) begin
      pc_r       <= pc_r + ADDR_W'(INSTR_BYTES);
      rd_valid_r <= 1'b1;
      rd_pc_r    <= pc_r;
    end else begin
      pc_r       <= pc_r;
      rd_valid_r <= 1'b0;
      rd_pc_r    <= rd_pc_r;
    end
  end

  fetch_imem #(
    .DATA_W    (DATA_W),
    .MEM_WORDS (MEM_WORDS)
  ) u_imem (
    .clk     (clk),
    .Reset   (Reset),
    .rd_en   (issue_s),
    .rd_idx  (pc_r[IDX_W+1:2]),
    .rd_data (rd_data_s)
  );

  // Output FIFO: returned words are pushed, handshakes pop, redirect flushes
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_instr_r[i] <= '0;
        buf_pc_r[i]    <= '0;
      end
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else if (redir_s) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (rd_valid_r) begin
        buf_instr_r[wptr_r] <= rd_data_s;
        buf_pc_r[wptr_r]    <= rd_pc_r;
        wptr_r              <= wptr_r + PTR_W'(1);
      end else begin
        wptr_r <= wptr_r;
      end
      if (pop_s) begin
        rptr_r <= rptr_r + PTR_W'(1);
      end else begin
        rptr_r <= rptr_r;
      end
      case ({rd_valid_r, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  // Sticky misalignment flag, cleared only by reset
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      misalign_err_r <= 1'b0;
    end else if (misalign_s) begin
      misalign_err_r <= 1'b1;
    end else begin
      misalign_err_r <= misalign_err_r;
    end
  end

  assign misalign_err = misalign_err_r;
`endif

  assign out_valid = (count_r != CNT_W'(0));
  assign out_instr = buf_instr_r[rptr_r];
  assign out_pc    = buf_pc_r[rptr_r];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then randomized
// ready/redirect traffic checked against a delivered-stream reference model.
module tb_fetch_stage;

  logic        clk;
  logic        Reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        misalign_err;
`endif

  int          checks;
  int          failures;
  logic [31:0] exp_pc;
  logic        err_model;

  fetch_stage dut (
    .clk            (clk),
    .Reset          (Reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .misalign_err   (misalign_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Expected ROM word at a byte address: 64-word image, word i holds
  // 0x13 in the top byte, i, 255-i, and 0x93 in the low byte.
  function automatic logic [31:0] ref_instr(input logic [31:0] addr);
    int unsigned i;
    i = (addr / 4) % 64;
    return 32'h1300_0093 + (i * 32'h0001_0000) + ((255 - i) * 32'h0000_0100);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one cycle; check any transfer, hold stability and redirect flush.
  task automatic step();
    logic        held;
    logic        flush;
    logic [31:0] h_pc;
    logic [31:0] h_instr;
    held    = out_valid && !out_ready && !redirect_valid;
    h_pc    = out_pc;
    h_instr = out_instr;
    flush   = 1'b0;
    if (out_valid && out_ready) begin
      chk("xfer_pc", out_pc, exp_pc);
      chk("xfer_instr", out_instr, ref_instr(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end
    if (redirect_valid) begin
`ifdef FETCH_MISALIGN_CHK_EN
      if (redirect_pc[1:0] == 2'b00) begin
        exp_pc = redirect_pc;
        flush  = 1'b1;
      end else begin
        err_model = 1'b1;
      end
`else
      exp_pc = redirect_pc & 32'hFFFF_FFFC;
      flush  = 1'b1;
`endif
    end
    @(posedge clk);
    #1;
    if (held) begin
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_pc", out_pc, h_pc);
      chk("hold_instr", out_instr, h_instr);
    end
    if (flush) chk("flush_valid", out_valid, 1'b0);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("misalign_err", misalign_err, err_model);
`endif
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (!out_valid && k < 10) begin
      step();
      k++;
    end
    chk(tag, out_valid, 1'b1);
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    exp_pc         = 32'h0;
    err_model      = 1'b0;
    Reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;

    // Reset state
    #2;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_pc_reg", dut.pc_r, 32'h0);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("rst_misalign", misalign_err, 1'b0);
`endif

    // Startup latency and back-to-back sequential stream
    @(negedge clk);
    Reset = 1'b1;
    @(posedge clk);
    #1;
    chk("lat_edge1_valid", out_valid, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("seq_valid", out_valid, 1'b1);
      chk("seq_pc", out_pc, 32'(i * 4));
      step();
    end

    // Asynchronous reset mid-stream
    #2;
    Reset = 1'b0;
    #1;
    chk("async_valid", out_valid, 1'b0);
    chk("async_pc", out_pc, 32'h0);
    chk("async_instr", out_instr, 32'h0);
    chk("async_pc_reg", dut.pc_r, 32'h0);
    @(negedge clk);
    exp_pc    = 32'h0;
    err_model = 1'b0;
    out_ready = 1'b0;
    Reset     = 1'b1;

    // Stall with out_ready low: head holds, PC stops once two words are buffered
    @(posedge clk);
    #1;
    chk("stall_edge1_valid", out_valid, 1'b0);
    step();
    chk("stall_first_valid", out_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_pc", out_pc, 32'h0);
      step();
    end
    chk("stall_pc_reg", dut.pc_r, 32'h8);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", out_valid, 1'b1);
      chk("drain_pc", out_pc, 32'(i * 4));
      step();
    end

    // Redirect while the buffer is full
    out_ready = 1'b0;
    step();
    step();
    step();
    chk("full_valid", out_valid, 1'b1);
    do_redirect(32'h40);
    out_ready = 1'b1;
    wait_valid("redir_full_valid");
    chk("redir_full_pc", out_pc, 32'h40);
    step();
    chk("redir_full_next", out_pc, 32'h44);
    step();

    // Redirect together with a handshake
    chk("same_valid", out_valid, 1'b1);
    do_redirect(32'h80);
    wait_valid("same_redir_valid");
    chk("same_redir_pc", out_pc, 32'h80);
    step();

    // PC wrap at the top of the address space
    do_redirect(32'hFFFF_FFFC);
    wait_valid("wrap_valid");
    chk("wrap_pc_top", out_pc, 32'hFFFF_FFFC);
    chk("wrap_instr_top", out_instr, ref_instr(32'hFFFF_FFFC));
    step();
    chk("wrap_valid0", out_valid, 1'b1);
    chk("wrap_pc0", out_pc, 32'h0);
    chk("wrap_instr0", out_instr, ref_instr(32'h0));
    step();

    // Misaligned redirect
    do_redirect(32'h42);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("misalign_set", misalign_err, 1'b1);
    wait_valid("misalign_stream_valid");
    chk("misalign_stream_pc", out_pc, exp_pc);
`else
    wait_valid("misalign_off_valid");
    chk("misalign_off_pc", out_pc, 32'h40);
`endif
    step();

    // Randomized ready and redirect traffic
    for (int n = 0; n < 600; n++) begin
      out_ready = ($urandom_range(9) < 7);
      if ($urandom_range(24) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom;
        if ($urandom_range(1) == 0) redirect_pc[1:0] = 2'b00;
      end else begin
        redirect_valid = 1'b0;
      end
      step();
    end
    redirect_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
